// File: rtl/pc_sequencer_if.sv
// Decode/PC-side bundle of requests, PC feedback and load controls for pc_sequencer.
interface pc_sequencer_if #(
   parameter int ADDR_W = 7
);
   logic              Start;
   logic              Halt;
   logic              Stall;
   logic              JumpReq;
   logic [ADDR_W-1:0] JumpAddr;
   logic              BranchReq;
   logic              BranchTaken;
   logic [ADDR_W-1:0] BranchOffset;
   logic              CallReq;
   logic              RetReq;
   logic [ADDR_W-1:0] PCResult;
   logic              PCWrite;
   logic [ADDR_W-1:0] PCNext;
   logic              Running;
   logic              RasOverflow;
   logic              RasUnderflow;

   modport master (
      output Start, Halt, Stall, JumpReq, JumpAddr, BranchReq, BranchTaken,
             BranchOffset, CallReq, RetReq, PCResult,
      input  PCWrite, PCNext, Running, RasOverflow, RasUnderflow
   );

   modport slave (
      input  Start, Halt, Stall, JumpReq, JumpAddr, BranchReq, BranchTaken,
             BranchOffset, CallReq, RetReq, PCResult,
      output PCWrite, PCNext, Running, RasOverflow, RasUnderflow
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter load sequencer: IDLE/RUN/HALTED control plus redirect selection.
// Define PCSEQ_RAS_EN to build the return-address stack for CallReq/RetReq.
module pc_sequencer #(
   parameter int                ADDR_W     = 7,
   parameter int                RAS_DEPTH  = 4,
   parameter logic [ADDR_W-1:0] START_ADDR = {ADDR_W{1'b0}}
) (
   input logic           Clk,
   input logic           Reset,
   pc_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t            state_r;
   logic              pc_write_r;
   logic [ADDR_W-1:0] pc_next_r;
   logic              running_r;
   logic [ADDR_W-1:0] branch_tgt_s;

`ifdef PCSEQ_RAS_EN
   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

   // ras_ptr_r indexes the next free slot; the stack wraps so a full push overwrites the oldest entry.
   logic [ADDR_W-1:0] ras_r [RAS_DEPTH];
   logic [PTR_W-1:0]  ras_ptr_r;
   logic [PTR_W-1:0]  ras_ptr_dec_s;
   logic [CNT_W-1:0]  ras_cnt_r;
   logic              ras_ovf_r;
   logic              ras_unf_r;
   logic [ADDR_W-1:0] ret_addr_s;
`else
   logic              unused_ret_s;
`endif

   // Relative targets derived from the fed-back PC
   always_comb begin
      branch_tgt_s = bus.PCResult + bus.BranchOffset;
`ifdef PCSEQ_RAS_EN
      ret_addr_s    = bus.PCResult + {{(ADDR_W-1){1'b0}}, 1'b1};
      ras_ptr_dec_s = ras_ptr_r - PTR_ONE;
`endif
   end

   // Sequencer state machine with registered PC load controls
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r    <= ST_IDLE;
         pc_write_r <= 1'b1;
         pc_next_r  <= START_ADDR;
         running_r  <= 1'b0;
`ifdef PCSEQ_RAS_EN
         ras_ptr_r <= '0;
         ras_cnt_r <= '0;
         ras_ovf_r <= 1'b0;
         ras_unf_r <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_r[i] <= {ADDR_W{1'b0}};
         end
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               pc_write_r <= 1'b1;
               pc_next_r  <= START_ADDR;
               if (bus.Start) begin
                  state_r   <= ST_RUN;
                  running_r <= 1'b1;
               end else begin
                  state_r   <= ST_IDLE;
                  running_r <= 1'b0;
               end
            end
            ST_HALTED: begin
               pc_write_r <= 1'b1;
               if (bus.Start) begin
                  state_r   <= ST_RUN;
                  running_r <= 1'b1;
                  pc_next_r <= START_ADDR;
               end else begin
                  state_r   <= ST_HALTED;
                  running_r <= 1'b0;
                  pc_next_r <= pc_next_r;
               end
            end
            ST_RUN: begin
               if (bus.Halt) begin
                  state_r    <= ST_HALTED;
                  running_r  <= 1'b0;
                  pc_write_r <= 1'b1;
                  pc_next_r  <= bus.PCResult;
               end else begin
                  state_r   <= ST_RUN;
                  running_r <= 1'b1;
                  if (bus.Stall) begin
                     pc_write_r <= 1'b1;
                     pc_next_r  <= bus.PCResult;
`ifdef PCSEQ_RAS_EN
                  end else if (bus.RetReq) begin
                     pc_write_r <= 1'b1;
                     if (ras_cnt_r != '0) begin
                        pc_next_r <= ras_r[ras_ptr_dec_s];
                        ras_ptr_r <= ras_ptr_dec_s;
                        ras_cnt_r <= ras_cnt_r - CNT_ONE;
                     end else begin
                        pc_next_r <= START_ADDR;
                        ras_unf_r <= 1'b1;
                     end
                  end else if (bus.CallReq) begin
                     pc_write_r       <= 1'b1;
                     pc_next_r        <= bus.JumpAddr;
                     ras_r[ras_ptr_r] <= ret_addr_s;
                     ras_ptr_r        <= ras_ptr_r + PTR_ONE;
                     if (ras_cnt_r == CNT_FULL) begin
                        ras_ovf_r <= 1'b1;
                     end else begin
                        ras_cnt_r <= ras_cnt_r + CNT_ONE;
                     end
`else
                  end else if (bus.CallReq) begin
                     pc_write_r <= 1'b1;
                     pc_next_r  <= bus.JumpAddr;
`endif
                  end else if (bus.JumpReq) begin
                     pc_write_r <= 1'b1;
                     pc_next_r  <= bus.JumpAddr;
                  end else if (bus.BranchReq && bus.BranchTaken) begin
                     pc_write_r <= 1'b1;
                     pc_next_r  <= branch_tgt_s;
                  end else begin
                     pc_write_r <= 1'b0;
                     pc_next_r  <= pc_next_r;
                  end
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               running_r  <= 1'b0;
               pc_write_r <= 1'b1;
               pc_next_r  <= START_ADDR;
            end
         endcase
      end
   end

   assign bus.PCWrite = pc_write_r;
   assign bus.PCNext  = pc_next_r;
   assign bus.Running = running_r;

`ifdef PCSEQ_RAS_EN
   assign bus.RasOverflow  = ras_ovf_r;
   assign bus.RasUnderflow = ras_unf_r;
`else
   assign bus.RasOverflow  = 1'b0;
   assign bus.RasUnderflow = 1'b0;
   assign unused_ret_s     = bus.RetReq;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table for RUN-state redirects plus
// hand sequences for start, RAS call/return, halt and mid-sequence reset.
module tb_pc_sequencer;

`ifdef PCSEQ_RAS_EN
   localparam bit RAS_EN = 1'b1;
`else
   localparam bit RAS_EN = 1'b0;
`endif

   logic Clk;
   logic Reset;
   int   tests;
   int   fails;

   pc_sequencer_if #(.ADDR_W(7)) bus ();

   pc_sequencer #(
      .ADDR_W     (7),
      .RAS_DEPTH  (4),
      .START_ADDR (7'd0)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      string      name;
      logic       stall;
      logic       jreq;
      logic [6:0] jaddr;
      logic       breq;
      logic       btaken;
      logic [6:0] boff;
      logic       creq;
      logic [6:0] pcres;
      logic       exp_w;
      logic [6:0] exp_n;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_load(input string name, input logic exp_w, input logic [6:0] exp_n);
      check({name, ".PCWrite"}, {31'd0, bus.PCWrite}, {31'd0, exp_w});
      if (exp_w) check({name, ".PCNext"}, {25'd0, bus.PCNext}, {25'd0, exp_n});
   endtask

   task automatic clear_inputs();
      bus.Start        = 1'b0;
      bus.Halt         = 1'b0;
      bus.Stall        = 1'b0;
      bus.JumpReq      = 1'b0;
      bus.JumpAddr     = 7'd0;
      bus.BranchReq    = 1'b0;
      bus.BranchTaken  = 1'b0;
      bus.BranchOffset = 7'd0;
      bus.CallReq      = 1'b0;
      bus.RetReq       = 1'b0;
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic start_run();
      clear_inputs();
      bus.Start    = 1'b1;
      bus.PCResult = 7'd0;
      step();
      check_load("start", 1'b1, 7'd0);
      bus.Start = 1'b0;
      step();
      check_load("start_next", 1'b0, 7'd0);
      check("start_running", {31'd0, bus.Running}, 32'd1);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      vecs[0]  = '{"free_run",     1'b0, 1'b0, 7'd0,   1'b0, 1'b0, 7'h00, 1'b0, 7'd1,   1'b0, 7'd0};
      vecs[1]  = '{"jump",         1'b0, 1'b1, 7'd40,  1'b0, 1'b0, 7'h00, 1'b0, 7'd10,  1'b1, 7'd40};
      vecs[2]  = '{"after_jump",   1'b0, 1'b0, 7'd0,   1'b0, 1'b0, 7'h00, 1'b0, 7'd40,  1'b0, 7'd0};
      vecs[3]  = '{"br_taken_neg", 1'b0, 1'b0, 7'd0,   1'b1, 1'b1, 7'h7E, 1'b0, 7'd5,   1'b1, 7'd3};
      vecs[4]  = '{"br_not_taken", 1'b0, 1'b0, 7'd0,   1'b1, 1'b0, 7'h7E, 1'b0, 7'd5,   1'b0, 7'd0};
      vecs[5]  = '{"br_wrap",      1'b0, 1'b0, 7'd0,   1'b1, 1'b1, 7'h05, 1'b0, 7'd126, 1'b1, 7'd3};
      vecs[6]  = '{"taken_no_req", 1'b0, 1'b0, 7'd0,   1'b0, 1'b1, 7'h04, 1'b0, 7'd20,  1'b0, 7'd0};
      vecs[7]  = '{"stall_wins",   1'b1, 1'b1, 7'd77,  1'b1, 1'b1, 7'h01, 1'b1, 7'd60,  1'b1, 7'd60};
      vecs[8]  = '{"jump_over_br", 1'b0, 1'b1, 7'd50,  1'b1, 1'b1, 7'h01, 1'b0, 7'd33,  1'b1, 7'd50};
      vecs[9]  = '{"jump_max",     1'b0, 1'b1, 7'd127, 1'b0, 1'b0, 7'h00, 1'b0, 7'd0,   1'b1, 7'd127};
      vecs[10] = '{"stall_only",   1'b1, 1'b0, 7'd0,   1'b0, 1'b0, 7'h00, 1'b0, 7'd7,   1'b1, 7'd7};

      clear_inputs();
      bus.PCResult = 7'd0;
      Reset = 1'b1;
      step();
      step();
      check_load("reset", 1'b1, 7'd0);
      check("reset_running", {31'd0, bus.Running}, 32'd0);
      check("reset_ovf", {31'd0, bus.RasOverflow}, 32'd0);
      check("reset_unf", {31'd0, bus.RasUnderflow}, 32'd0);
      Reset = 1'b0;
      bus.Halt = 1'b1;
      step();
      check_load("idle_pin", 1'b1, 7'd0);
      check("idle_running", {31'd0, bus.Running}, 32'd0);

      start_run();

      foreach (vecs[i]) begin
         clear_inputs();
         bus.Stall        = vecs[i].stall;
         bus.JumpReq      = vecs[i].jreq;
         bus.JumpAddr     = vecs[i].jaddr;
         bus.BranchReq    = vecs[i].breq;
         bus.BranchTaken  = vecs[i].btaken;
         bus.BranchOffset = vecs[i].boff;
         bus.CallReq      = vecs[i].creq;
         bus.PCResult     = vecs[i].pcres;
         step();
         check_load(vecs[i].name, vecs[i].exp_w, vecs[i].exp_n);
         check({vecs[i].name, ".Running"}, {31'd0, bus.Running}, 32'd1);
      end

      // Five calls into a four-deep stack, one stalled call, then five returns
      for (int i = 0; i < 5; i++) begin
         clear_inputs();
         bus.CallReq  = 1'b1;
         bus.JumpAddr = 7'(100 + i);
         bus.PCResult = 7'(10 * (i + 1));
         step();
         check_load($sformatf("call%0d", i), 1'b1, 7'(100 + i));
         check($sformatf("call%0d_ovf", i), {31'd0, bus.RasOverflow},
               {31'd0, (RAS_EN && (i == 4))});
      end
      clear_inputs();
      bus.Stall    = 1'b1;
      bus.CallReq  = 1'b1;
      bus.JumpReq  = 1'b1;
      bus.JumpAddr = 7'd99;
      bus.PCResult = 7'd60;
      step();
      check_load("stall_call", 1'b1, 7'd60);
      for (int i = 0; i < 5; i++) begin
         clear_inputs();
         bus.RetReq   = 1'b1;
         bus.PCResult = 7'd90;
         step();
         check_load($sformatf("ret%0d", i), RAS_EN,
                    (i == 4) ? 7'd0 : 7'(51 - 10 * i));
         check($sformatf("ret%0d_unf", i), {31'd0, bus.RasUnderflow},
               {31'd0, (RAS_EN && (i == 4))});
      end

      // Halt freezes at the current PC; requests and Halt ignored until Start
      clear_inputs();
      bus.Halt     = 1'b1;
      bus.PCResult = 7'd60;
      step();
      check_load("halt", 1'b1, 7'd60);
      check("halt_running", {31'd0, bus.Running}, 32'd0);
      clear_inputs();
      bus.JumpReq  = 1'b1;
      bus.JumpAddr = 7'd15;
      bus.Halt     = 1'b1;
      step();
      check_load("halted_hold", 1'b1, 7'd60);
      clear_inputs();
      step();
      check_load("halted_hold2", 1'b1, 7'd60);
      start_run();

      // Reset in the middle of a call sequence discards stack and flags
      for (int i = 0; i < 2; i++) begin
         clear_inputs();
         bus.CallReq  = 1'b1;
         bus.JumpAddr = 7'(110 + i);
         bus.PCResult = 7'(12 + 10 * i);
         step();
         check_load($sformatf("precall%0d", i), 1'b1, 7'(110 + i));
      end
      clear_inputs();
      bus.CallReq  = 1'b1;
      bus.JumpAddr = 7'd70;
      Reset = 1'b1;
      step();
      check_load("mid_reset", 1'b1, 7'd0);
      check("mid_reset_ovf", {31'd0, bus.RasOverflow}, 32'd0);
      check("mid_reset_unf", {31'd0, bus.RasUnderflow}, 32'd0);
      Reset = 1'b0;
      clear_inputs();
      step();
      check_load("post_reset_idle", 1'b1, 7'd0);
      check("post_reset_running", {31'd0, bus.Running}, 32'd0);
      start_run();
      clear_inputs();
      bus.RetReq   = 1'b1;
      bus.PCResult = 7'd2;
      step();
      check_load("ret_after_reset", RAS_EN, 7'd0);
      check("ret_after_reset_unf", {31'd0, bus.RasUnderflow}, {31'd0, RAS_EN});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control block that drives the PCWrite/PCNext inputs of the 7-bit program counter.
- Tells the counter when to free-run and when to load a redirect target: jump, taken branch, call, return, stall hold, halt and start address.
- Holds a small return-address stack (RAS) for call/return.
- Sits between instruction decode and the program counter; reads the current PCResult back to compute relative targets.

Parameters:
- ADDR_W, 7, width of PC addresses.
- RAS_DEPTH, 4, number of return-address stack entries (power of two, 2..8).
- START_ADDR, 7'd0, address loaded on Start and on return-stack underflow.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle pulse; leaves IDLE/HALTED and loads START_ADDR.
- Halt  input  1  freeze the PC and enter HALTED.
- Stall  input  1  hold the PC at its current value this cycle.
- JumpReq  input  1  absolute jump request.
- JumpAddr  input  ADDR_W  jump target.
- BranchReq  input  1  conditional branch present.
- BranchTaken  input  1  condition result; qualified by BranchReq.
- BranchOffset  input  ADDR_W  signed two's-complement offset, relative to PCResult.
- CallReq  input  1  call to JumpAddr; pushes the return address.
- RetReq  input  1  return to the popped RAS address.
- PCResult  input  ADDR_W  current PC value fed back from the counter.
- PCWrite  output  1  load strobe to the counter.
- PCNext  output  ADDR_W  load value to the counter.
- Running  output  1  high in RUN state.
- RasOverflow  output  1  sticky flag: call issued with RAS full.
- RasUnderflow  output  1  sticky flag: return issued with RAS empty.

Behaviour:
- Reset (synchronous, active-high):
  - State=IDLE, PCWrite=1, PCNext=START_ADDR.
  - RAS pointer=0, count=0, both flags=0, Running=0.
  - Reset mid-operation discards any pending request and RAS contents.
- FSM states: IDLE, RUN, HALTED.
  - IDLE: PCWrite=1, PCNext=START_ADDR (pins PC). Start -> RUN; the load of START_ADDR stays asserted for that cycle.
  - RUN: processes requests. Halt -> HALTED.
  - HALTED: PCWrite=1, PCNext=PC value latched at halt entry. Start -> RUN with PCNext=START_ADDR. Halt is ignored in IDLE/HALTED.
- All outputs are registered: a request sampled at edge N produces PCWrite/PCNext valid from edge N until N+1. Latency is 1 cycle.
- Redirects assert PCWrite for exactly one cycle. With no request, PCWrite=0 and the counter free-runs.
- Priority in RUN, highest first: Halt > Stall > RetReq > CallReq > JumpReq > (BranchReq & BranchTaken). Lower requests in the same cycle are dropped, not queued.
- Targets (all arithmetic modulo 2^ADDR_W, wrap silent):
  - Stall: PCNext=PCResult.
  - Jump: PCNext=JumpAddr.
  - Branch taken: PCNext=PCResult+BranchOffset, offset sign-extended.
  - Branch not taken: no write.
- Call: push PCResult+1 (127+1 wraps to 0), then PCNext=JumpAddr.
  - If RAS is full (count==RAS_DEPTH): overwrite the oldest entry (circular), count stays at RAS_DEPTH, set RasOverflow.
- Ret with RAS non-empty: PCNext=top entry, pop.
  - If RAS is empty: PCNext=START_ADDR, set RasUnderflow, count stays 0.
- Stall blocks all RAS push/pop in that cycle.
- Flags clear only on Reset.

Optional Feature:
- Macro: PCSEQ_RAS_EN.
- Defined: RAS and both flags operate as described above.
- Undefined:
  - No RAS storage.
  - CallReq is treated as JumpReq (same priority slot as Call).
  - RetReq is ignored (no write).
  - RasOverflow and RasUnderflow are tied to 0.

Test Plan:
- Reset, then Start pulse -> PCWrite=1, PCNext=0 for one cycle; next cycle Running=1, PCWrite=0, and the counter increments 0,1,2...
- At PCResult=10: JumpReq with JumpAddr=40 -> one cycle later PCWrite=1, PCNext=40; following cycle PCWrite=0.
- At PCResult=5: BranchReq=1, BranchTaken=1, BranchOffset=7'h7E (-2) -> PCNext=3. Repeat with BranchTaken=0 -> PCWrite stays 0.
- Five calls from PCResult=10,20,30,40,50 with RAS_DEPTH=4:
  - RasOverflow=1.
  - Four returns yield PCNext=51,41,31,21.
  - A fifth return yields PCNext=0 with RasUnderflow=1.
- Same cycle, Stall=1, JumpReq=1, CallReq=1 at PCResult=60 -> PCNext=60, PCWrite=1, RAS count unchanged. Then Halt -> HALTED holds PCNext=60 until Start.
- Reset asserted mid-call sequence (RAS count=2) -> next cycle IDLE, flags=0, and a following Ret after Start gives RasUnderflow=1.
